// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: merges in-order WB results with buffered
// long-latency results and tracks pending long-latency destinations.
module rf_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_rd,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        raw_stall,
    output logic [31:0] pend_mask,
    output logic        wb_hold,
    output logic        sb_err,
    output logic        rf_wr,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_entry_t;

    ll_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [STV_W-1:0] starve_cnt, starve_nxt;
    logic [31:0]      pend, pend_nxt, set_mask, clr_mask;
    ll_entry_t        head;
    logic             empty, full, pop, push;
    logic             sel_valid, issue_conflict, err_set;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    // Port selection, FIFO handshake, scoreboard and starvation next-state
    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(FIFO_DEPTH));
        head      = mem[rd_ptr];
        pop       = !wb_valid && !empty;
        ll_ready  = !full || pop;
        push      = ll_valid && ll_ready;
        sel_valid = wb_valid || pop;
        sel_rd    = wb_valid ? wb_rd : head.rd;
        sel_data  = wb_valid ? wb_data : head.data;

        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        set_mask = '0;
        clr_mask = '0;
        if (ll_issue && ll_issue_rd != 5'd0) set_mask = 32'h1 << ll_issue_rd;
        if (pop && head.rd != 5'd0)          clr_mask = 32'h1 << head.rd;
        pend_nxt = ((pend & ~clr_mask) | set_mask) & ~32'h1;

        issue_conflict = ll_issue && (ll_issue_rd != 5'd0) && pend[ll_issue_rd];
        err_set        = issue_conflict && !clr_mask[ll_issue_rd];
        raw_stall      = ((rs1 != 5'd0) && pend[rs1]) ||
                         ((rs2 != 5'd0) && pend[rs2]) || issue_conflict;

        // Non-empty and not popping means wb_valid is blocking the head
        starve_nxt = starve_cnt;
        if (empty || pop)                          starve_nxt = '0;
        else if (starve_cnt != STV_W'(STARVE_MAX)) starve_nxt = starve_cnt + STV_W'(1);
    end

    // Result buffer storage; contents are only meaningful under count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: ll_rd, data: ll_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pend       <= '0;
            wb_hold    <= 1'b0;
            sb_err     <= 1'b0;
            rf_wr      <= 1'b0;
            rf_a3      <= '0;
            rf_wd      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            pend       <= pend_nxt;
            wb_hold    <= (starve_nxt == STV_W'(STARVE_MAX));
            if (err_set) sb_err <= 1'b1;
            // rd==0 is consumed without a write; address/data still track it
            rf_wr <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rf_a3 <= sel_rd;
                rf_wd <= sel_data;
            end
        end
    end

    assign pend_mask = pend;
endmodule
